uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter for the icestick 12 MHz domain.
- A small FIFO sits in front of it, fed through a valid/ready byte interface.
- It drives the board `tx` pin and complements the existing UART receive path in `top`.
- Default timing gives 115200 baud: 104 clocks per bit, about 8.67 µs.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit (12 MHz / 115200, truncated); must be ≥ 2.
- FIFO_DEPTH, 4, byte entries buffered; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  FIFO non-empty or frame in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
  - Reset values: tx=1, in_ready=1, busy=0, fifo_count=0, FSM=IDLE, bit counter=0, baud counter=0.
- Reset mid-frame:
  - Aborts the frame; tx is 1 from the next edge.
  - FIFO contents are discarded; no partial frame resumes.
- Push:
  - A byte is accepted on any edge where in_valid && in_ready.
  - in_ready = (fifo_count < FIFO_DEPTH), decoded from the registered count.
  - A push attempted while full is ignored; the data is lost and the counters are unchanged.
  - This holds even when a pop occurs on the same edge.
- Pop happens only in IDLE with fifo_count≠0, or at the end of STOP with fifo_count≠0.
- Simultaneous push and pop (not full): fifo_count unchanged; pointers both advance, wrapping modulo FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP. The baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - IDLE: tx=1.
    - If fifo_count≠0: pop the head into the shift register, registered tx←0, baud counter←0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then tx←shift[0], bit index←0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first.
    - After bit 7: tx←1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - Then, if fifo_count≠0: pop, tx←0, go to START with no idle gap.
    - Else go to IDLE.
- Latency: byte accepted on edge E with FIFO empty and FSM in IDLE → tx low from edge E+2.
- Frame length is exactly 10×CLKS_PER_BIT clocks. Back-to-back frames start every 10×CLKS_PER_BIT clocks.
- busy = (state≠IDLE) || (fifo_count≠0), registered-equivalent; it is 0 only when the line is idle and the FIFO is empty.
- tx is driven from a flop; there is no combinational path from inputs to tx.
- Width rules: the baud counter is $clog2(CLKS_PER_BIT) bits and the bit index is 3 bits. The FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Shared package/include `uart_pkg`:
  - CLK_HZ=12_000_000.
  - BAUD=115200.
  - CLKS_PER_BIT derived constant, shared with the receiver.
  - FSM state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3).
- Sub-module `byte_fifo`: synchronous FIFO (push/pop/count/full/empty) parameterised by depth. uart_tx_fifo instantiates it alongside the FSM.

Test Plan:
- Single byte: push 0x55 once after reset, CLKS_PER_BIT=104.
  - tx falls 2 clocks after the accept edge.
  - Then the levels 0,1,0,1,0,1,0,1,0,1 hold 104 clocks each (start, LSB-first data, stop).
  - Then tx=1 and busy=0.
- Back-to-back: push 0xFF then 0x00 on consecutive cycles.
  - Second start bit begins exactly 1040 clocks after the first.
  - No extra idle cycle between frames; fifo_count steps 1,2,1,0 (second byte popped at end of first stop).
- FIFO full: hold in_valid with bytes 0x11,0x01,0x02,0x03,0x04,0x05 from idle.
  - First byte popped → 0x01..0x04 fill the FIFO; in_ready=0 while fifo_count=4.
  - 0x05 accepted only after the next pop.
  - Serial output order is 0x11,0x01,0x02,0x03,0x04,0x05.
- Reset mid-frame: push 0xA5 and 0x3C; assert rst_n=0 for 1 clock during data bit 3.
  - tx=1 on the next edge; fifo_count=0, busy=0, in_ready=1.
  - No further frames are emitted.
- Push ignored when full: with fifo_count=4, drive in_valid with 0xEE.
  - fifo_count unchanged; 0xEE never appears on tx.
- Loopback: connect tx to the existing receiver rx and send 0xFF,0x00,0x11,0x01,0x02,0x03,0x04.
  - The receiver reports identical bytes in order, with no framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding.
// The receive path uses the same bit timing.
package uart_pkg;
    localparam int CLK_HZ       = 12_000_000;
    localparam int BAUD         = 115200;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a registered occupancy count.
// A push while full is dropped, even if a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
//   state | meaning
//   IDLE  | line high, waiting for a buffered byte
//   START | start bit (low) for CLKS_PER_BIT clocks
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); chains into the next START if a byte is waiting
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import uart_pkg::*;

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_avail;
    logic          w_baud_end;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign in_ready   = !w_full;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign w_baud_end = (r_baud == BAUD_LAST);

    // IDLE starts on a registered copy of "FIFO non-empty", so a byte written
    // into an empty FIFO reaches the line two edges after it is accepted.
    assign w_pop = !w_empty &&
                   (((r_state == IDLE) && r_avail) || ((r_state == STOP) && w_baud_end));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_avail <= 1'b0;
        end else begin
            r_avail <= !w_empty;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, bit timing, chaining, FIFO limits,
// reset abort and a serial decode of the line.
module tb_uart_tx_fifo;
    localparam int CPB   = 104;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int cyc     = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] seq [8];
    logic [7:0] got [8];
    logic       ok_f [8];
    int         acc_cyc [8];
    int         seq_n;
    int         ready_bad;
    logic       full_seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit, then samples mid-bit like a UART receiver.
    task automatic rx_frame(output logic [7:0] b, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        b  = 8'h00;
        while (tx !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            ok = 1'b0;
            return;
        end
        repeat (CPB/2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic push_stream();
        int   guard;
        int   k;
        logic rdy;
        guard = 0;
        k     = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = seq[0];
        while (k < seq_n && guard < 20000) begin
            rdy = in_ready;
            if (fifo_count == 3'(DEPTH)) begin
                full_seen = 1'b1;
                if (in_ready !== 1'b0) ready_bad++;
            end
            @(negedge clk);
            guard++;
            if (rdy) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < seq_n) in_data = seq[k];
                else           in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_stream();
        for (int k = 0; k < seq_n; k++) rx_frame(got[k], ok_f[k]);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 12000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int         e;
        int         t;
        int         lows;
        logic [9:0] lvl;
        logic [7:0] b;
        logic       ok;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_tx",    tx, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 0x55: start, 1,0,1,0,1,0,1,0, stop
        lvl      = 10'b1010101010;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        e        = cyc;
        in_valid = 1'b0;
        chk("one_count_e", fifo_count, 1);
        chk("one_busy_e",  busy, 1);
        chk("one_tx_e",    tx, 1);
        @(negedge clk);
        chk("one_tx_e1",   tx, 1);
        for (int k = 0; k < 10; k++) begin
            lows = 0;
            repeat (CPB) begin
                @(negedge clk);
                if (tx !== lvl[k]) lows++;
            end
            chk($sformatf("one_slot%0d_badcycles", k), lows, 0);
        end
        @(negedge clk);
        chk("one_end_cyc",  cyc - e, 1042);
        chk("one_end_tx",   tx, 1);
        chk("one_end_busy", busy, 0);
        wait_idle();

        // Back-to-back 0xFF, 0x00
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        e       = cyc;
        in_data = 8'h00;
        chk("b2b_count_1", fifo_count, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_count_2", fifo_count, 2);
        @(negedge clk);
        chk("b2b_count_3", fifo_count, 1);
        chk("b2b_start1",  tx, 0);
        repeat (1039) @(negedge clk);
        chk("b2b_stop1_tx",    tx, 1);
        chk("b2b_stop1_count", fifo_count, 1);
        @(negedge clk);
        chk("b2b_start2_tx",    tx, 0);
        chk("b2b_start2_count", fifo_count, 0);
        t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_end_cyc", cyc - e, 2082);
        wait_idle();

        // FIFO fill with in_valid held
        seq[0] = 8'h11; seq[1] = 8'h01; seq[2] = 8'h02;
        seq[3] = 8'h03; seq[4] = 8'h04; seq[5] = 8'h05;
        seq_n     = 6;
        ready_bad = 0;
        full_seen = 1'b0;
        fork
            push_stream();
            recv_stream();
        join
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fill_byte%0d", k), got[k], seq[k]);
            chk($sformatf("fill_frame%0d_ok", k), ok_f[k], 1);
        end
        chk("fill_accept4_cyc", acc_cyc[4] - acc_cyc[0], 4);
        chk("fill_accept5_cyc", acc_cyc[5] - acc_cyc[0], 1043);
        chk("fill_full_seen",   full_seen, 1);
        chk("fill_ready_bad",   ready_bad, 0);
        wait_idle();

        // Push of 0xEE while full is dropped
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        in_data = 8'hEE;
        repeat (3) @(negedge clk);
        chk("drop_count", fifo_count, 4);
        chk("drop_ready", in_ready, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_frame(b, ok);
            chk($sformatf("drop_byte%0d", i), b, 8'hA0 + 8'(i));
            chk($sformatf("drop_frame%0d_ok", i), ok, 1);
        end
        lows = 0;
        repeat (1200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("drop_no_extra_frame", lows, 0);
        wait_idle();

        // Reset during data bit 3 of 0xA5 (bit 3 is 0)
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        e       = cyc;
        in_data = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (469) @(negedge clk);
        chk("rmid_bit3_cyc", cyc - e, 470);
        chk("rmid_bit3_tx",  tx, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rmid_tx",    tx, 1);
        chk("rmid_count", fifo_count, 0);
        chk("rmid_busy",  busy, 0);
        chk("rmid_ready", in_ready, 1);
        lows = 0;
        repeat (2500) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("rmid_no_frames", lows, 0);

        // Serial decode of a burst
        seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h11; seq[3] = 8'h01;
        seq[4] = 8'h02; seq[5] = 8'h03; seq[6] = 8'h04;
        seq_n     = 7;
        ready_bad = 0;
        full_seen = 1'b0;
        fork
            push_stream();
            recv_stream();
        join
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("loop_byte%0d", k), got[k], seq[k]);
            chk($sformatf("loop_frame%0d_ok", k), ok_f[k], 1);
        end
        chk("loop_ready_bad", ready_bad, 0);
        wait_idle();
        chk("loop_idle_tx", tx, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
